// File: rtl/conv_nm_stream_pkg.sv
// Shared types and helpers for the N-sample / M-tap stream convolver.
//   conv_state_t : controller states (LOAD, MAC, OUT).
//   conv_ow()    : full-precision result width for a dw-bit, m-tap dot product.
package conv_pkg;

    typedef enum logic [1:0] {
        LOAD,
        MAC,
        OUT
    } conv_state_t;

    // Worst case magnitude is M * 2^(2*dw-2), which needs 2*dw + clog2(m) bits signed.
    function automatic int conv_ow(input int dw, input int m);
        return 2 * dw + $clog2(m);
    endfunction

endpackage

// File: rtl/conv_nm_stream_if.sv
// Stream bundle for conv_nm_stream: x and f input streams, filter-hold strobe
// and the y output stream.
//   slave  : the convolver side (consumes x/f, produces y).
//   master : the environment side.
interface conv_nm_stream_if
    import conv_pkg::*;
#(
    parameter int DW = 8,
    parameter int M  = 4
);
    localparam int OW = conv_ow(DW, M);

    logic signed [DW-1:0] s_data_x;
    logic                 s_valid_x;
    logic                 s_ready_x;
    logic signed [DW-1:0] s_data_f;
    logic                 s_valid_f;
    logic                 s_ready_f;
    logic                 hold_f;
    logic signed [OW-1:0] m_data_y;
    logic                 m_valid_y;
    logic                 m_ready_y;

    modport slave (
        input  s_data_x, s_valid_x, s_data_f, s_valid_f, hold_f, m_ready_y,
        output s_ready_x, s_ready_f, m_data_y, m_valid_y
    );

    modport master (
        output s_data_x, s_valid_x, s_data_f, s_valid_f, hold_f, m_ready_y,
        input  s_ready_x, s_ready_f, m_data_y, m_valid_y
    );
endinterface

// File: rtl/conv_nm_stream_mac_p.sv
// P-lane signed dot product with accumulator register.
//   clk, reset : clock, synchronous active-high reset (clears acc).
//   clr        : zero the accumulator on the next edge (has priority over en).
//   en         : add sum_k x_slice[k]*f_slice[k] to the accumulator.
//   x_slice/f_slice : P signed samples / coefficients.
//   acc        : accumulator value, OW = conv_ow(DW, M) bits signed.
module conv_mac_p
    import conv_pkg::*;
#(
    parameter int DW = 8,
    parameter int M  = 4,
    parameter int P  = 4
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  clr,
    input  logic                                  en,
    input  logic signed [DW-1:0]                  x_slice [P],
    input  logic signed [DW-1:0]                  f_slice [P],
    output logic signed [conv_ow(DW, M)-1:0]      acc
);
    localparam int OW = conv_ow(DW, M);

    logic signed [2*DW-1:0] prod [P];
    logic signed [OW-1:0]   sum;
    logic signed [OW-1:0]   acc_q, acc_d;

    // Products are sign-extended to the full output width before summing.
    always_comb begin
        sum = '0;
        for (int k = 0; k < P; k++) begin
            prod[k] = (2*DW)'(x_slice[k]) * (2*DW)'(f_slice[k]);
            sum     = sum + OW'(prod[k]);
        end
    end

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + sum;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;
endmodule

// File: rtl/conv_nm_stream.sv
// Parametrised 1-D convolution engine: loads N signed x samples and M signed
// taps over valid/ready streams, then emits y[i] = sum_j x[i+j]*f[j] for
// i = 0..N-M, computing P products per cycle.  hold_f, sampled on the accept
// of the last y, keeps the current taps for the next vector.
//   clk, reset : clock, synchronous active-high reset.
//   bus        : conv_nm_stream_if.slave (x/f input streams, hold_f, y stream).
module conv_nm_stream
    import conv_pkg::*;
#(
    parameter int DW = 8,
    parameter int N  = 8,
    parameter int M  = 4,
    parameter int P  = 4
) (
    input  logic              clk,
    input  logic              reset,
    conv_nm_stream_if.slave   bus
);
    localparam int OW  = conv_ow(DW, M);
    localparam int XIW = (N > 1) ? $clog2(N) : 1;
    localparam int XCW = $clog2(N + 1);
    localparam int FIW = (M > 1) ? $clog2(M) : 1;
    localparam int FCW = $clog2(M + 1);

    localparam logic [XCW-1:0] X_FULL = XCW'(N);
    localparam logic [FCW-1:0] F_FULL = FCW'(M);
    localparam logic [XIW-1:0] I_LAST = XIW'(N - M);
    localparam logic [FIW-1:0] J_LAST = FIW'(M - P);
    localparam logic [FIW-1:0] J_STEP = FIW'(P);

    if (M % P != 0) begin : g_bad_p
        $error("conv_nm_stream: M must be a multiple of P");
    end
    if (N < M) begin : g_bad_n
        $error("conv_nm_stream: N must be at least M");
    end

    conv_state_t          state_q, state_d;
    logic [XCW-1:0]       x_cnt_q, x_cnt_d;
    logic [FCW-1:0]       f_cnt_q, f_cnt_d;
    logic                 f_loaded_q, f_loaded_d;
    logic [XIW-1:0]       i_q, i_d;
    logic [FIW-1:0]       j_q, j_d;

    logic signed [DW-1:0] x_reg [N];
    logic signed [DW-1:0] f_reg [M];

    logic                 acc_clr, acc_en;
    logic signed [DW-1:0] x_slice [P];
    logic signed [DW-1:0] f_slice [P];
    logic signed [OW-1:0] acc;
    logic [XIW-1:0]       base;
    logic                 x_fire, f_fire;

    assign bus.s_ready_x = (state_q == LOAD) && (x_cnt_q < X_FULL);
    assign bus.s_ready_f = (state_q == LOAD) && (f_cnt_q < F_FULL) && !f_loaded_q;
    assign bus.m_valid_y = (state_q == OUT);
    // The accumulator is frozen in OUT, so it doubles as the held result.
    assign bus.m_data_y  = acc;

    assign x_fire = bus.s_valid_x && bus.s_ready_x;
    assign f_fire = bus.s_valid_f && bus.s_ready_f;

    always_comb begin
        state_d    = state_q;
        x_cnt_d    = x_cnt_q;
        f_cnt_d    = f_cnt_q;
        f_loaded_d = f_loaded_q;
        i_d        = i_q;
        j_d        = j_q;
        acc_clr    = 1'b0;
        acc_en     = 1'b0;
        case (state_q)
            LOAD: begin
                if (x_fire) x_cnt_d = x_cnt_q + XCW'(1);
                if (f_fire) f_cnt_d = f_cnt_q + FCW'(1);
                // Decided on registered counts: MAC starts one edge after the last transfer.
                if (x_cnt_q == X_FULL && (f_cnt_q == F_FULL || f_loaded_q)) begin
                    state_d = MAC;
                    i_d     = '0;
                    j_d     = '0;
                    acc_clr = 1'b1;
                end
            end
            MAC: begin
                acc_en = 1'b1;
                if (j_q == J_LAST) begin
                    state_d = OUT;
                end else begin
                    j_d = j_q + J_STEP;
                end
            end
            OUT: begin
                if (bus.m_ready_y) begin
                    if (i_q == I_LAST) begin
                        state_d = LOAD;
                        x_cnt_d = '0;
                        if (bus.hold_f) begin
                            f_loaded_d = 1'b1;
                        end else begin
                            f_cnt_d    = '0;
                            f_loaded_d = 1'b0;
                        end
                    end else begin
                        state_d = MAC;
                        i_d     = i_q + XIW'(1);
                        j_d     = '0;
                        acc_clr = 1'b1;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= LOAD;
            x_cnt_q    <= '0;
            f_cnt_q    <= '0;
            f_loaded_q <= 1'b0;
            i_q        <= '0;
            j_q        <= '0;
        end else begin
            state_q    <= state_d;
            x_cnt_q    <= x_cnt_d;
            f_cnt_q    <= f_cnt_d;
            f_loaded_q <= f_loaded_d;
            i_q        <= i_d;
            j_q        <= j_d;
        end
    end

    // Sample storage needs no reset: the counters decide what is valid.
    always_ff @(posedge clk) begin
        if (x_fire) x_reg[x_cnt_q[XIW-1:0]] <= bus.s_data_x;
        if (f_fire) f_reg[f_cnt_q[FIW-1:0]] <= bus.s_data_f;
    end

    // i+j+k stays below N and j+k below M for every reachable (i, j).
    always_comb begin
        base = i_q + XIW'(j_q);
        for (int k = 0; k < P; k++) begin
            x_slice[k] = x_reg[base + XIW'(k)];
            f_slice[k] = f_reg[j_q + FIW'(k)];
        end
    end

    conv_mac_p #(.DW(DW), .M(M), .P(P)) u_mac (
        .clk     (clk),
        .reset   (reset),
        .clr     (acc_clr),
        .en      (acc_en),
        .x_slice (x_slice),
        .f_slice (f_slice),
        .acc     (acc)
    );
endmodule

// File: tb/tb_conv_nm_stream.sv
module tb_conv_nm_stream;
    import conv_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    conv_nm_stream_if #(.DW(8), .M(4)) ifa ();
    conv_nm_stream_if #(.DW(8), .M(8)) ifb ();
    conv_nm_stream_if #(.DW(8), .M(4)) ifc ();

    conv_nm_stream #(.DW(8), .N(8),  .M(4), .P(4)) dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
    conv_nm_stream #(.DW(8), .N(16), .M(8), .P(2)) dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));
    conv_nm_stream #(.DW(8), .N(8),  .M(4), .P(1)) dut_c (.clk(clk), .reset(reset), .bus(ifc.slave));

    int n_cmp = 0;
    int n_err = 0;

    function automatic int cfg_n(input int s);
        return (s == 1) ? 16 : 8;
    endfunction

    function automatic int cfg_m(input int s);
        return (s == 1) ? 8 : 4;
    endfunction

    // Reference: direct evaluation of y[i] = sum_j x[i+j]*f[j].
    function automatic int conv_at(input int xv[$], input int fv[$], input int i);
        int acc;
        acc = 0;
        for (int j = 0; j < fv.size(); j++) acc += xv[i + j] * fv[j];
        return acc;
    endfunction

    function automatic int rnd8();
        logic signed [7:0] r;
        r = 8'($urandom);
        return int'(r);
    endfunction

    task automatic set_in(input int s, input logic vx, input logic [7:0] dx, input logic vf,
                          input logic [7:0] df, input logic h, input logic rdy);
        case (s)
            0: begin
                ifa.s_valid_x = vx; ifa.s_data_x = dx; ifa.s_valid_f = vf; ifa.s_data_f = df;
                ifa.hold_f = h; ifa.m_ready_y = rdy;
            end
            1: begin
                ifb.s_valid_x = vx; ifb.s_data_x = dx; ifb.s_valid_f = vf; ifb.s_data_f = df;
                ifb.hold_f = h; ifb.m_ready_y = rdy;
            end
            default: begin
                ifc.s_valid_x = vx; ifc.s_data_x = dx; ifc.s_valid_f = vf; ifc.s_data_f = df;
                ifc.hold_f = h; ifc.m_ready_y = rdy;
            end
        endcase
    endtask

    task automatic get_out(input int s, output logic rx, output logic rf, output logic vy,
                           output int y, output logic yx);
        case (s)
            0: begin
                rx = ifa.s_ready_x; rf = ifa.s_ready_f; vy = ifa.m_valid_y;
                y = int'(ifa.m_data_y); yx = $isunknown(ifa.m_data_y);
            end
            1: begin
                rx = ifb.s_ready_x; rf = ifb.s_ready_f; vy = ifb.m_valid_y;
                y = int'(ifb.m_data_y); yx = $isunknown(ifb.m_data_y);
            end
            default: begin
                rx = ifc.s_ready_x; rf = ifc.s_ready_f; vy = ifc.m_valid_y;
                y = int'(ifc.m_data_y); yx = $isunknown(ifc.m_data_y);
            end
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_all();
        for (int s = 0; s < 3; s++) set_in(s, 1'b0, 8'bx, 1'b0, 8'bx, 1'b0, 1'b0);
    endtask

    // Offers x (and f if send_f) with valid held high until everything is taken.
    task automatic load_vector(input int s, input int xv[$], input int fv[$], input bit send_f,
                               output bit saw_rf, output bit tmo);
        int xi, fi;
        logic vx, vf, rx, rf, vy, yx;
        int y;
        xi = 0; fi = 0; saw_rf = 1'b0; tmo = 1'b1;
        for (int c = 0; c < 200; c++) begin
            vx = (xi < xv.size());
            vf = send_f && (fi < fv.size());
            set_in(s, vx, vx ? 8'(xv[xi]) : 8'bx, vf, vf ? 8'(fv[fi]) : 8'bx, 1'b0, 1'b0);
            get_out(s, rx, rf, vy, y, yx);
            if (rf) saw_rf = 1'b1;
            tick();
            if (vx && rx) xi++;
            if (vf && rf) fi++;
            if (xi == xv.size() && (!send_f || fi == fv.size())) begin
                tmo = 1'b0;
                break;
            end
        end
        set_in(s, 1'b0, 8'bx, 1'b0, 8'bx, 1'b0, 1'b0);
    endtask

    // Waits (bounded) for one y with m_ready_y high and lets it be accepted.
    task automatic take_y(input int s, input logic hold, output int y, output bit tmo);
        logic rx, rf, vy, yx;
        int yv;
        tmo = 1'b1; y = 0;
        for (int c = 0; c < 100; c++) begin
            set_in(s, 1'b0, 8'bx, 1'b0, 8'bx, hold, 1'b1);
            get_out(s, rx, rf, vy, yv, yx);
            tick();
            if (vy) begin
                y = yv;
                tmo = 1'b0;
                break;
            end
        end
        set_in(s, 1'b0, 8'bx, 1'b0, 8'bx, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        logic rx, rf, vy, yx;
        int y;
        reset = 1'b1;
        idle_all();
        tick();
        tick();
        for (int s = 0; s < 3; s++) begin
            get_out(s, rx, rf, vy, y, yx);
            n_cmp++;
            if (vy !== 1'b0 || yx || y != 0 || rx !== 1'b1 || rf !== 1'b1) begin
                n_err++;
                $display("FAIL reset_state dut%0d: valid=%b data=%0d rdy_x=%b rdy_f=%b, want 0/0/1/1",
                         s, vy, y, rx, rf);
            end
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int xv[$], fv[$];
        bit saw, tmo;
        logic rx, rf, vy, yx;
        int y;
        logic [2:0] seen;
        xv = '{1, 2, 3, 4, 5, 6, 7, 8};
        fv = '{1, 1, 1, 1};
        load_vector(0, xv, fv, 1'b1, saw, tmo);
        get_out(0, rx, rf, vy, y, yx); seen[0] = vy;
        tick();
        get_out(0, rx, rf, vy, y, yx); seen[1] = vy;
        tick();
        get_out(0, rx, rf, vy, y, yx); seen[2] = vy;
        n_cmp++;
        if (tmo || seen !== 3'b100) begin
            n_err++;
            $display("FAIL basic_latency: valid after edges 0/1/2 = %b%b%b (load timeout %0d), want 0/0/1",
                     seen[0], seen[1], seen[2], tmo);
        end
        for (int i = 0; i < 5; i++) begin
            take_y(0, 1'b0, y, tmo);
            n_cmp++;
            if (tmo || y != conv_at(xv, fv, i)) begin
                n_err++;
                $display("FAIL basic_y%0d: got %0d (timeout %0d), want %0d", i, y, tmo, conv_at(xv, fv, i));
            end
        end
    endtask

    task automatic test_extremes();
        int xv[$], fv[$];
        bit saw, tmo;
        int y;
        for (int v = 0; v < 2; v++) begin
            xv = '{-128, -128, -128, -128, -128, -128, -128, -128};
            fv = (v == 0) ? '{-128, -128, -128, -128} : '{127, 127, 127, 127};
            load_vector(0, xv, fv, 1'b1, saw, tmo);
            for (int i = 0; i < 5; i++) begin
                take_y(0, 1'b0, y, tmo);
                n_cmp++;
                if (tmo || y != conv_at(xv, fv, i)) begin
                    n_err++;
                    $display("FAIL extreme%0d_y%0d: got %0d (timeout %0d), want %0d",
                             v, i, y, tmo, conv_at(xv, fv, i));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int xv[$], fv[$];
        bit saw, tmo;
        logic rx, rf, vy, yx;
        int y, y0;
        bit got;
        xv = '{1, 2, 3, 4, 5, 6, 7, 8};
        fv = '{1, 1, 1, 1};
        load_vector(0, xv, fv, 1'b1, saw, tmo);
        got = 1'b0; y0 = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            get_out(0, rx, rf, vy, y, yx);
            if (vy) begin got = 1'b1; y0 = y; end
            else tick();
        end
        n_cmp++;
        if (!got || tmo) begin
            n_err++;
            $display("FAIL bp_first_valid: no y within bound (load timeout %0d)", tmo);
        end
        for (int c = 0; c < 10; c++) begin
            set_in(0, 1'b1, 8'd5, 1'b1, 8'd5, 1'b0, 1'b0);
            get_out(0, rx, rf, vy, y, yx);
            n_cmp++;
            if (vy !== 1'b1 || y != y0 || y != conv_at(xv, fv, 0) || rx !== 1'b0 || rf !== 1'b0) begin
                n_err++;
                $display("FAIL bp_stall%0d: valid=%b data=%0d rdy_x=%b rdy_f=%b, want 1/%0d/0/0",
                         c, vy, y, rx, rf, conv_at(xv, fv, 0));
            end
            tick();
        end
        set_in(0, 1'b0, 8'bx, 1'b0, 8'bx, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            take_y(0, 1'b0, y, tmo);
            n_cmp++;
            if (tmo || y != conv_at(xv, fv, i)) begin
                n_err++;
                $display("FAIL bp_y%0d: got %0d (timeout %0d), want %0d", i, y, tmo, conv_at(xv, fv, i));
            end
        end
    endtask

    task automatic test_hold();
        int x1[$], x2[$], f1[$], f3[$];
        bit saw, tmo;
        int y;
        x1 = '{1, 2, 3, 4, 5, 6, 7, 8};
        x2 = '{8, 7, 6, 5, 4, 3, 2, 1};
        f1 = '{1, 2, 3, 4};
        f3 = '{1, 1, 1, 1};
        load_vector(0, x1, f1, 1'b1, saw, tmo);
        for (int i = 0; i < 5; i++) begin
            take_y(0, (i == 4), y, tmo);
            n_cmp++;
            if (tmo || y != conv_at(x1, f1, i)) begin
                n_err++;
                $display("FAIL hold_v1_y%0d: got %0d (timeout %0d), want %0d", i, y, tmo, conv_at(x1, f1, i));
            end
        end
        load_vector(0, x2, f1, 1'b0, saw, tmo);
        n_cmp++;
        if (tmo || saw) begin
            n_err++;
            $display("FAIL hold_no_f_ready: s_ready_f seen=%0d timeout=%0d, want 0/0", saw, tmo);
        end
        for (int i = 0; i < 5; i++) begin
            take_y(0, 1'b0, y, tmo);
            n_cmp++;
            if (tmo || y != conv_at(x2, f1, i)) begin
                n_err++;
                $display("FAIL hold_v2_y%0d: got %0d (timeout %0d), want %0d", i, y, tmo, conv_at(x2, f1, i));
            end
        end
        // hold_f was low on the last accept, so a new filter must be taken again.
        load_vector(0, x1, f3, 1'b1, saw, tmo);
        n_cmp++;
        if (tmo) begin
            n_err++;
            $display("FAIL hold_release: filter not accepted after release (timeout %0d), want 0", tmo);
        end
        for (int i = 0; i < 5; i++) begin
            take_y(0, 1'b0, y, tmo);
            n_cmp++;
            if (tmo || y != conv_at(x1, f3, i)) begin
                n_err++;
                $display("FAIL hold_v3_y%0d: got %0d (timeout %0d), want %0d", i, y, tmo, conv_at(x1, f3, i));
            end
        end
    endtask

    task automatic test_reset_mid();
        int xv[$], fv[$];
        bit saw, tmo;
        logic rx, rf, vy, yx;
        int y;
        bit got;
        xv = '{1, 2, 3, 4, 5, 6, 7, 8};
        fv = '{1, 1, 1, 1};
        load_vector(0, xv, fv, 1'b1, saw, tmo);
        take_y(0, 1'b0, y, tmo);
        take_y(0, 1'b0, y, tmo);
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            get_out(0, rx, rf, vy, y, yx);
            if (vy) got = 1'b1;
            else tick();
        end
        reset = 1'b1;
        tick();
        get_out(0, rx, rf, vy, y, yx);
        n_cmp++;
        if (!got || vy !== 1'b0 || rx !== 1'b1 || rf !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_state: reached OUT=%0d valid=%b rdy_x=%b rdy_f=%b, want 1/0/1/1",
                     got, vy, rx, rf);
        end
        reset = 1'b0;
        tick();
        load_vector(0, xv, fv, 1'b1, saw, tmo);
        for (int i = 0; i < 5; i++) begin
            take_y(0, 1'b0, y, tmo);
            n_cmp++;
            if (tmo || y != conv_at(xv, fv, i)) begin
                n_err++;
                $display("FAIL midreset_y%0d: got %0d (timeout %0d), want %0d", i, y, tmo, conv_at(xv, fv, i));
            end
        end
    endtask

    task automatic test_random(input int s, input int nvec);
        int n, m, nout, xi, fi, yi, y;
        int xv[$], fcur[$], yexp[$];
        bit held, hold_last, done;
        logic vx, vf, rdy, h, rx, rf, vy, yx;
        n = cfg_n(s); m = cfg_m(s); nout = n - m + 1;
        held = 1'b0;
        for (int v = 0; v < nvec; v++) begin
            xv = {};
            for (int i = 0; i < n; i++) xv.push_back(rnd8());
            if (!held) begin
                fcur = {};
                for (int j = 0; j < m; j++) fcur.push_back(rnd8());
            end
            yexp = {};
            for (int i = 0; i < nout; i++) yexp.push_back(conv_at(xv, fcur, i));
            hold_last = ($urandom_range(0, 3) == 0);
            xi = 0; fi = held ? m : 0; yi = 0; done = 1'b0;
            for (int c = 0; c < 3000; c++) begin
                vx  = (xi < n) && ($urandom_range(0, 1) == 1);
                vf  = (fi < m) && ($urandom_range(0, 1) == 1);
                rdy = ($urandom_range(0, 2) != 0);
                h   = (yi == nout - 1) ? hold_last : 1'($urandom);
                set_in(s, vx, vx ? 8'(xv[xi]) : 8'bx, vf, vf ? 8'(fcur[fi]) : 8'bx, h, rdy);
                get_out(s, rx, rf, vy, y, yx);
                if (vy) begin
                    n_cmp++;
                    if (yx || y != yexp[yi] || rx || rf) begin
                        n_err++;
                        $display("FAIL rand%0d_v%0d_y%0d: got %0d (x=%0d rdy_x=%b rdy_f=%b), want %0d",
                                 s, v, yi, y, yx, rx, rf, yexp[yi]);
                    end
                end
                if (held) begin
                    n_cmp++;
                    if (rf) begin
                        n_err++;
                        $display("FAIL rand%0d_v%0d_held_f: s_ready_f=%b, want 0", s, v, rf);
                    end
                end
                tick();
                if (vx && rx) xi++;
                if (vf && rf) fi++;
                if (vy && rdy) begin
                    yi++;
                    if (yi == nout) begin
                        done = 1'b1;
                        break;
                    end
                end
            end
            if (!done) begin
                n_cmp++;
                n_err++;
                $display("FAIL rand%0d_v%0d_timeout: %0d of %0d y seen, want all", s, v, yi, nout);
                break;
            end
            held = hold_last;
        end
        set_in(s, 1'b0, 8'bx, 1'b0, 8'bx, 1'b0, 1'b0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_all();
        test_reset();
        test_basic();
        test_extremes();
        test_backpressure();
        test_hold();
        test_reset_mid();
        test_random(0, 300);
        test_random(1, 100);
        test_random(2, 200);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
